// File: rtl/v_serial_pkg.sv
// Shared definitions for the serial deframer: FSM encoding, default sync byte
// and the width of one buffered entry {sof, eof, byte}.
package v_serial_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         ENTRY_W      = 10;

endpackage

// File: rtl/v_fifo2.sv
// Two-entry synchronous FIFO; a push while full is accepted only when a pop
// frees a slot on the same edge.
module v_fifo2
    import v_serial_pkg::*;
(
    input  logic               C,
    input  logic               R,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         cnt;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge C) begin
        if (R) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/v_serial_deframer.sv
// Serial receive stage: hunts for a sync byte, then packs FRAME_LEN payload
// bytes MSB-first into a 2-entry valid/ready buffer with SOF/EOF tags.
module v_serial_deframer
    import v_serial_pkg::*;
#(
    parameter logic [7:0] SYNC      = SYNC_DEFAULT,
    parameter int         FRAME_LEN = 4
) (
    input  logic       C,
    input  logic       R,
    input  logic       CE,
    input  logic       SI,
    output logic [7:0] DO,
    output logic       SOF,
    output logic       EOF,
    output logic       DV,
    input  logic       DR,
    output logic       OVF,
    output logic       LOCK
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

    state_t     state, state_n;
    logic [7:0] win, win_n;
    logic [7:0] acc, acc_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] byte_cnt, byte_n;
    logic       ovf, ovf_n;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] win_sh;
    logic [7:0] acc_sh;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;

    assign win_sh = {win[6:0], SI};
    assign acc_sh = {acc[6:0], SI};
    assign din    = {(byte_cnt == 8'd0), (byte_cnt == LAST_BYTE), acc_sh};
    assign pop    = DR & ~empty;

    always_ff @(posedge C) begin
        if (R) begin
            state    <= HUNT;
            win      <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            win      <= win_n;
            acc      <= acc_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            ovf      <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        win_n   = win;
        acc_n   = acc;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        ovf_n   = ovf;
        push    = 1'b0;
        if (CE) begin
            case (state)
                HUNT: begin
                    win_n = win_sh;
                    if (win_sh == SYNC) begin
                        state_n = PAYLOAD;
                        bit_n   = '0;
                        byte_n  = '0;
                    end
                end
                PAYLOAD: begin
                    acc_n = acc_sh;
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        push = 1'b1;
                        // Dropped bytes still advance the byte count so EOF stays aligned.
                        if (full && !pop) ovf_n = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state_n = HUNT;
                            win_n   = '0;
                            byte_n  = '0;
                        end else begin
                            byte_n = byte_cnt + 8'd1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    v_fifo2 u_fifo (
        .C    (C),
        .R    (R),
        .push (push),
        .din  (din),
        .pop  (pop),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    assign {SOF, EOF, DO} = dout;
    assign DV   = ~empty;
    assign OVF  = ovf;
    assign LOCK = (state == PAYLOAD);

endmodule

// File: tb/tb_v_serial_deframer.sv
// Bench for v_serial_deframer: serial frames in, scoreboarded {SOF,EOF,DO}
// transfers out, plus lock, overflow, CE-gap and reset scenarios.
module tb_v_serial_deframer;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       CE = 1'b0;
    logic       SI = 1'b0;
    logic       DR = 1'b0;
    logic [7:0] DO;
    logic       SOF, EOF, DV, OVF, LOCK;

    logic [9:0] exp_q[$];
    logic [7:0] pay [4];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         gaps  = 1'b0;

    v_serial_deframer dut (
        .C(C), .R(R), .CE(CE), .SI(SI), .DO(DO), .SOF(SOF), .EOF(EOF),
        .DV(DV), .DR(DR), .OVF(OVF), .LOCK(LOCK)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: DR/DV are stable from #1 after posedge, so the
    // negedge view matches what the next posedge sees.
    always @(negedge C) begin
        if (!R && DV && DR) begin
            if (exp_q.size() == 0) check("xfer_extra", 32'(DV), 32'd0);
            else check("xfer", {22'd0, SOF, EOF, DO}, {22'd0, exp_q.pop_front()});
        end
    end

    task automatic idle(input int n);
        CE = 1'b0;
        repeat (n) begin
            @(posedge C);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        if (gaps) idle($urandom_range(0, 2));
        SI = b;
        CE = 1'b1;
        @(posedge C);
        #1;
        CE = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_sync(input string tag);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(s[i]);
            check(tag, 32'(LOCK), (i == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic new_payload();
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    // Sends pay[0..3]; only the first `keep` bytes are expected to arrive.
    task automatic send_payload(input int keep);
        for (int i = 0; i < 4; i++) begin
            if (i < keep) exp_q.push_back({(i == 0), (i == 3), pay[i]});
            send_byte(pay[i]);
            if (i == 1) check("lock_mid", 32'(LOCK), 32'd1);
        end
        check("lock_fall", 32'(LOCK), 32'd0);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge C);
            #1;
            t++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        R  = 1'b1;
        CE = 1'b0;
        @(posedge C);
        #1;
        R = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge C);
        #1;
        do_reset();
        check("rst_dv", 32'(DV), 0);
        check("rst_do", 32'(DO), 0);
        check("rst_sof", 32'(SOF), 0);
        check("rst_eof", 32'(EOF), 0);
        check("rst_ovf", 32'(OVF), 0);
        check("rst_lock", 32'(LOCK), 0);

        // Clean frame
        DR = 1'b1;
        send_sync("lock_clean");
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_payload(4);
        drain("drain_clean");
        check("ovf_clean", 32'(OVF), 0);

        // Misaligned sync, then a near-match that must not lock
        send_bit(1'b0);
        send_bit(1'b1);
        send_sync("lock_misalign");
        new_payload();
        send_payload(4);
        drain("drain_misalign");
        begin
            logic [7:0] nm;
            nm = 8'hA4;
            for (int i = 7; i >= 0; i--) begin
                send_bit(nm[i]);
                check("lock_a4", 32'(LOCK), 0);
            end
        end
        send_sync("lock_after_a4");
        new_payload();
        send_payload(4);
        drain("drain_after_a4");

        // Backpressure and overflow
        DR = 1'b0;
        send_sync("lock_bp");
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_payload(2);
        check("bp_ovf", 32'(OVF), 1);
        check("bp_dv", 32'(DV), 1);
        idle(3);
        check("bp_hold_do", 32'(DO), 32'h11);
        check("bp_hold_sof", 32'(SOF), 1);
        DR = 1'b1;
        drain("drain_bp");
        idle(1);
        check("bp_dv_after", 32'(DV), 0);
        check("bp_ovf_sticky", 32'(OVF), 1);

        // CE gaps
        gaps = 1'b1;
        send_sync("lock_gaps");
        new_payload();
        send_payload(4);
        gaps = 1'b0;
        drain("drain_gaps");

        // Reset mid-frame: one buffered byte and a partial byte are lost
        DR = 1'b0;
        send_sync("lock_rst");
        new_payload();
        send_byte(pay[0]);
        check("lat_dv", 32'(DV), 1);
        check("lat_do", 32'(DO), 32'(pay[0]));
        for (int i = 0; i < 5; i++) send_bit(pay[1][7-i]);
        do_reset();
        check("mid_rst_dv", 32'(DV), 0);
        check("mid_rst_lock", 32'(LOCK), 0);
        check("mid_rst_ovf", 32'(OVF), 0);
        DR = 1'b1;
        send_sync("lock_post_rst");
        new_payload();
        send_payload(4);
        drain("drain_post_rst");

        // Full buffer with a pop on the edge of the 8th bit
        DR = 1'b0;
        send_sync("lock_full");
        new_payload();
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), (i == 3), pay[i]});
        send_byte(pay[0]);
        send_byte(pay[1]);
        for (int i = 7; i >= 1; i--) send_bit(pay[2][i]);
        DR = 1'b1;
        send_bit(pay[2][0]);
        check("full_ovf", 32'(OVF), 0);
        send_byte(pay[3]);
        drain("drain_full");
        check("full_ovf_end", 32'(OVF), 0);
        idle(2);
        check("final_dv", 32'(DV), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/v_serial_deframer.md
# v_serial_deframer

Serial-to-parallel receive stage that sits directly downstream of the 8-bit negative-edge shift register and consumes its serial output (SO) one bit per enabled clock. It hunts the bit stream for a sync byte, then assembles a fixed-length payload into bytes, MSB first. Completed bytes are delivered through a 2-entry valid/ready output buffer with start- and end-of-frame markers. It samples on the rising edge of C, so it captures the upstream SO mid-bit, half a cycle after the upstream negedge update.

## Interface
- SYNC, 8'hA5, sync byte that opens a frame.
- FRAME_LEN, 4, payload bytes per frame; legal range 1..255.
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous active-high reset.
- CE  input  1  bit strobe; SI is consumed only on edges where CE=1.
- SI  input  1  serial data, connected to the upstream SO.
- DO  output  8  payload byte at the head of the buffer.
- SOF  output  1  head byte is the first byte of its frame.
- EOF  output  1  head byte is the last byte of its frame.
- DV  output  1  head entry is valid.
- DR  input  1  consumer ready; a byte transfers on an edge where DV=1 and DR=1.
- OVF  output  1  sticky flag: a completed byte was dropped because the buffer was full.
- LOCK  output  1  high while in PAYLOAD.

## Operation
- **Reset.** While R=1 at an edge, the block clears all state. After reset: state=HUNT, window=0, bit count=0, byte count=0, buffer empty, DV=0, DO=0, SOF=0, EOF=0, OVF=0, LOCK=0. R has priority over every other input.
- **Bit order.** The first received bit lands in bit 7 of a byte, matching the left-shift, MSB-out order of the upstream stage. Each new bit is shifted in as {acc[6:0], SI}.
- **HUNT state.**
  - On each CE edge, the 8-bit window updates to {win[6:0], SI}.
  - If the updated value equals SYNC, go to PAYLOAD with bit count=0 and byte count=0.
  - The window is not cleared between frames. A frame is detected as soon as the last 8 received bits equal SYNC.
- **PAYLOAD state.**
  - On each CE edge, shift SI into the accumulator and increment the bit count.
  - On the 8th bit, push {acc[6:0], SI} into the buffer, tagged SOF=(byte count==0) and EOF=(byte count==FRAME_LEN-1). The bit count wraps to 0.
  - After the EOF byte is pushed, return to HUNT and clear the window to 0. A sync byte must therefore be received in full after each frame.
- **CE=0.** No state change except buffer pops.
- **Buffer.**
  - 2 entries of {SOF, EOF, byte}, FIFO order.
  - A push is accepted if the buffer is not full, or if a pop happens on the same edge. This gives a simultaneous pop and push when full.
  - Otherwise the byte is discarded and OVF is set. The frame still advances (byte count increments), so EOF tracking stays aligned.
- **Arithmetic.**
  - Bit count: 3 bits, modulo 8.
  - Byte count: 8 bits; it never exceeds FRAME_LEN-1.
  - Buffer occupancy: 0..2.

## Timing
- Latency from the CE edge carrying the 8th payload bit to DV=1 is 1 edge, when the buffer was empty.
- DO, SOF and EOF are registered. They are stable while DV=1 and DR=0.
- A transfer on edge n exposes the next entry (or DV=0) after edge n.
- When DR is held high, sustained throughput is 1 byte per 8 CE edges, so there is never overflow.
- LOCK rises after the edge that completes SYNC. It falls after the edge that pushes the EOF byte.
- Reset mid-frame: any partial byte and all buffered bytes are lost, and DV=0 after the reset edge.

## Structure
- Shared package v_serial_pkg holds:
  - state encoding localparams HUNT=1'b0 and PAYLOAD=1'b1;
  - the default SYNC value;
  - the buffer entry width (10).
- Sub-module v_fifo2 implements the 2-entry synchronous FIFO. Its ports are C, R, push, din[9:0], pop, dout[9:0], full, empty. The deframer instantiates one v_fifo2; the FSM, window, accumulator and counters live in the top.

## Test plan
- **Clean frame.** With CE=1 and DR=1, send A5 followed by 11 22 33 44 MSB-first. Expect 4 transfers 11(SOF), 22, 33, 44(EOF), and OVF=0.
- **Sync misalignment.** Send bits 0,1 then A5 then 4 bytes. Expect the same 4 bytes, with lock occurring exactly after the A5 bits. Then send a false near-match 0xA4 before the next A5 and expect no lock.
- **Backpressure and overflow.** Hold DR=0 for a full frame. Expect 11 and 22 retained, 33 and 44 dropped, and OVF=1. Raise DR and expect 11(SOF) then 22, DV=0 afterwards, and OVF still 1.
- **CE gaps.** Insert random CE=0 cycles during a frame. Expect identical bytes, and expect DO/DV to change only on CE edges or transfers.
- **Reset mid-frame.** Apply R after 13 payload bits. Expect DV=0, LOCK=0 and OVF=0 on the next edge. A following A5 + frame is received correctly.
- **Full plus simultaneous pop/push.** With the buffer full and DR=1 on the edge of the 8th bit, expect the new byte accepted and OVF to remain 0.
